mmu: RTL and testbench

MMU -- requirements
Module: mmu

---
 rtl/mmu.sv | 80 ++++++++
 tb/tb_mmu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mmu.sv
// mmu -- single-level segment translation unit.
//
// A 16-entry segment table maps the top nibble of a 24-bit virtual address
// onto a 4-bit physical segment. The 20-bit offset passes through unchanged.
// Translation is registered: one result per clock, one cycle of latency, and
// no combinational path from addr_a to addr_b.
//
// Parameters
//   LEVEL     cache-hierarchy level served. 0 gives an identity reset mapping.
//             Any other value flips the segment MSB (pseg = i ^ 4'h8).
//
// Ports
//   clk       rising-edge clock for all state
//   rst       synchronous, active-high reset
//   addr_a    [23:0] virtual address to translate
//   addr_b    [23:0] translated physical address (registered)
//   fault     1 = last translated address hit an invalid segment (registered)
//   cfg_we    table write strobe, one cycle per write
//   cfg_idx   [3:0]  table entry to write
//   cfg_pseg  [3:0]  physical segment to store
//   cfg_valid         valid bit to store
module mmu #(
  parameter int LEVEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] addr_a,
  output logic [23:0] addr_b,
  output logic        fault,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [3:0]  cfg_pseg,
  input  logic        cfg_valid
);

  // Reset mapping: identity for level 0, MSB-flipped for every other level.
  localparam logic [3:0] RST_XOR = (LEVEL == 0) ? 4'h0 : 4'h8;

  logic [3:0]  r_pseg [16];
  logic [15:0] r_valid;
  logic [23:0] r_addr_b;
  logic        r_fault;

  logic [3:0]  w_vseg;
  logic [3:0]  w_pseg;
  logic        w_hit;

  assign w_vseg = addr_a[23:20];
  assign w_pseg = r_pseg[w_vseg];
  assign w_hit  = r_valid[w_vseg];

  // The lookup reads the table as it stands before this edge. A write to the
  // same entry in the same cycle is seen only from the next edge onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_b <= 24'h000000;
      r_fault  <= 1'b0;
      r_valid  <= 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
        r_pseg[i] <= 4'(i) ^ RST_XOR;
      end
    end else begin
      if (w_hit) begin
        r_addr_b <= {w_pseg, addr_a[19:0]};
        r_fault  <= 1'b0;
      end else begin
        r_addr_b <= 24'h000000;
        r_fault  <= 1'b1;
      end
      if (cfg_we) begin
        r_pseg[cfg_idx]  <= cfg_pseg;
        r_valid[cfg_idx] <= cfg_valid;
      end
    end
  end

  assign addr_b = r_addr_b;
  assign fault  = r_fault;

endmodule

// File: tb/tb_mmu.sv
// Scoreboard bench for mmu. Three instances (LEVEL 0, 1 and 5) share one
// stimulus stream. The driver pushes the expected result of every cycle.
// The monitor pops that result one cycle later and compares it.
module tb_mmu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] addr_a = 24'h0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = 4'h0;
  logic [3:0]  cfg_pseg = 4'h0;
  logic        cfg_valid = 1'b0;

  logic [2:0][23:0] addr_b;
  logic [2:0]       fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mmu #(.LEVEL(0)) u_l0 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b[0]), .fault(fault[0]),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pseg(cfg_pseg), .cfg_valid(cfg_valid));
  mmu #(.LEVEL(1)) u_l1 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b[1]), .fault(fault[1]),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pseg(cfg_pseg), .cfg_valid(cfg_valid));
  mmu #(.LEVEL(5)) u_l5 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b[2]), .fault(fault[2]),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pseg(cfg_pseg), .cfg_valid(cfg_valid));

  typedef struct packed {
    logic [2:0][23:0] a;
    logic [2:0]       f;
  } exp_t;

  exp_t q[$];

  // Reference table: one per instance. Instance 0 is level 0; the others map
  // segment i to i with the top bit flipped.
  int m_pseg [3][16];
  bit m_val  [3][16];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        m_pseg[k][i] = (k == 0) ? i : (i ^ 8);
        m_val[k][i]  = 1'b1;
      end
  endfunction

  task automatic step(input logic [23:0] a, input logic we, input logic [3:0] idx,
                      input logic [3:0] ps, input logic v, input logic r);
    exp_t e;
    int seg;
    @(negedge clk);
    addr_a = a; cfg_we = we; cfg_idx = idx; cfg_pseg = ps; cfg_valid = v; rst = r;
    seg = int'(a) / 24'h100000;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        e.a[k] = 24'h0; e.f[k] = 1'b0;
      end else if (m_val[k][seg]) begin
        e.a[k] = 24'(m_pseg[k][seg] * 24'h100000 + (int'(a) % 24'h100000));
        e.f[k] = 1'b0;
      end else begin
        e.a[k] = 24'h0; e.f[k] = 1'b1;
      end
    end
    q.push_back(e);
    // The table update takes effect only after this cycle's lookup.
    if (r) model_reset();
    else if (we)
      for (int k = 0; k < 3; k++) begin
        m_pseg[k][idx] = int'(ps);
        m_val[k][idx]  = v;
      end
  endtask

  // Monitor: one result per clock, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (addr_b[k] !== e.a[k]) begin
            errors++;
            $display("FAIL addr_b inst%0d cyc%0d: got %h want %h", k, cyc, addr_b[k], e.a[k]);
          end
          checks++;
          if (fault[k] !== e.f[k]) begin
            errors++;
            $display("FAIL fault inst%0d cyc%0d: got %b want %b", k, cyc, fault[k], e.f[k]);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset, then check the reset mapping (address 0 and address 232323).
    step(24'h000000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(24'h000000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(24'h232323, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    // Same-cycle write with lookup uses the old entry; the next cycle sees the new one.
    step(24'h232323, 1'b1, 4'h2, 4'h5, 1'b1, 1'b0);
    step(24'h232323, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    // Invalidate segment 3: that segment faults, other segments are untouched.
    step(24'h000000, 1'b1, 4'h3, 4'hF, 1'b0, 1'b0);
    step(24'h3ABCDE, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(24'h123456, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    // Writes with cfg_we low must be ignored.
    step(24'h232323, 1'b0, 4'h2, 4'h9, 1'b0, 1'b0);
    step(24'h232323, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    // A write during reset is discarded, and reset clears earlier writes.
    step(24'h3ABCDE, 1'b1, 4'h2, 4'h7, 1'b0, 1'b1);
    step(24'h232323, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(24'h3ABCDE, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(24'hFFFFFF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(24'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
    end
    step(24'h000000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
